// File: rtl/lc3_fetch.sv
// LC-3 fetch unit: one outstanding memory read feeding a DEPTH-entry instruction FIFO.
// Define LC3_FETCH_PERF_EN to add the fetch_count port (instructions delivered to the core).
module lc3_fetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] cmd,
    output logic [15:0] cmd_pc,
    output logic        cmd_valid,
    input  logic        cmd_ready
`ifdef LC3_FETCH_PERF_EN
    ,
    output logic [15:0] fetch_count
`endif
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] word;
    } entry_t;

    state_t        state_q;
    logic          req_q;
    logic [15:0]   addr_q;
    logic [15:0]   pc_q;
    entry_t        buf_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          ack;
    logic          push;
    logic          pop;
    logic          full_d;
    logic [15:0]   next_pc;

    assign ack       = req_q & mem_ack;
    assign cmd_valid = (cnt_q != '0);
    assign pop       = cmd_valid & cmd_ready;
    // Only responses to requests made in FETCH are kept; a redirect kills the word in flight.
    assign push      = ack & (state_q == FETCH) & ~redirect;
    assign next_pc   = ack ? pc_q + 16'd1 : pc_q;

    assign mem_req   = req_q;
    assign mem_addr  = addr_q;
    assign cmd       = cmd_valid ? buf_q[rd_q].word : '0;
    assign cmd_pc    = cmd_valid ? buf_q[rd_q].pc   : '0;

    always_comb begin
        cnt_d = cnt_q;
        if (redirect)
            cnt_d = '0;
        else if (push && !pop)
            cnt_d = cnt_q + (AW+1)'(1);
        else if (pop && !push)
            cnt_d = cnt_q - (AW+1)'(1);
    end

    assign full_d = (cnt_d == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (redirect) begin
                rd_q <= '0;
                wr_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + AW'(1);
                if (pop)  rd_q <= rd_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) buf_q[wr_q] <= '{pc: pc_q, word: mem_rdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
        end else if (redirect) begin
            pc_q <= redirect_pc;
            // A request still in flight must be retired before the new stream starts.
            if (req_q && !mem_ack) begin
                state_q <= DRAIN;
            end else begin
                state_q <= FETCH;
                req_q   <= 1'b1;
                addr_q  <= redirect_pc;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (!req_q || mem_ack) begin
                        pc_q <= next_pc;
                        if (full_d) begin
                            state_q <= HOLD;
                            req_q   <= 1'b0;
                        end else begin
                            req_q  <= 1'b1;
                            addr_q <= next_pc;
                        end
                    end
                end
                HOLD: begin
                    if (pop) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                default: begin
                    state_q <= FETCH;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef LC3_FETCH_PERF_EN
    logic [15:0] fcnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fcnt_q <= '0;
        else if (pop)
            fcnt_q <= fcnt_q + 16'd1;
    end

    assign fetch_count = fcnt_q;
`endif

endmodule

// File: tb/tb_lc3_fetch.sv
// Bench for lc3_fetch: directed scenarios plus a randomized run against an in-order PC stream model.
module tb_lc3_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] cmd;
    logic [15:0] cmd_pc;
    logic        cmd_valid;
    logic        cmd_ready;
`ifdef LC3_FETCH_PERF_EN
    logic [15:0] fetch_count;
`endif

    int checks = 0;
    int passed = 0;
    int ack_delay = 0;
    int wait_n = 0;
    bit rand_delay = 1'b0;

    lc3_fetch dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .cmd(cmd), .cmd_pc(cmd_pc), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready)
`ifdef LC3_FETCH_PERF_EN
        , .fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    // Advance one cycle, then play the memory: ack after ack_delay cycles of waiting.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_ack) begin
            wait_n = 0;
            if (rand_delay) ack_delay = $urandom_range(0, 3);
        end else if (mem_req) begin
            wait_n++;
        end
        mem_ack   = mem_req && (wait_n >= ack_delay);
        mem_rdata = mem_ack ? memf(mem_addr) : 16'($urandom);
    endtask

    task automatic reset_dut();
        rst = 1'b1; redirect = 1'b0; cmd_ready = 1'b0; mem_ack = 1'b0;
        wait_n = 0; ack_delay = 0; rand_delay = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; cmd_ready = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0; wait_n = 0; ack_delay = 0;
        @(posedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_req); else passed++;
        checks++; if (mem_addr !== 16'h0001) $display("FAIL rst_mem_addr: got %h want 0001", mem_addr); else passed++;
        checks++; if (cmd !== 16'h0000) $display("FAIL rst_cmd: got %h want 0000", cmd); else passed++;
        checks++; if (cmd_pc !== 16'h0000) $display("FAIL rst_cmd_pc: got %h want 0000", cmd_pc); else passed++;
        checks++; if (cmd_valid !== 1'b0) $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); else passed++;
`ifdef LC3_FETCH_PERF_EN
        checks++; if (fetch_count !== 16'h0000) $display("FAIL rst_fetch_count: got %h want 0000", fetch_count); else passed++;
`endif
        rst = 1'b0;
        tick();
        checks++; if (mem_req !== 1'b1) $display("FAIL first_req: got %b want 1", mem_req); else passed++;
        checks++; if (mem_addr !== 16'h0001) $display("FAIL first_addr: got %h want 0001", mem_addr); else passed++;
    endtask

    task automatic test_stream();
        logic [15:0] k;
        reset_dut();
        cmd_ready = 1'b1;
        tick();
        checks++; if (cmd_valid !== 1'b0) $display("FAIL stream_no_bypass: got %b want 0", cmd_valid); else passed++;
        for (int i = 2; i <= 8; i++) begin
            tick();
            k = 16'(i);
            checks++; if (mem_addr !== k) $display("FAIL stream_addr: got %h want %h", mem_addr, k); else passed++;
            checks++; if (cmd_valid !== 1'b1 || cmd_pc !== k - 16'd1)
                $display("FAIL stream_cmd_pc: got v=%b pc=%h want v=1 pc=%h", cmd_valid, cmd_pc, k - 16'd1); else passed++;
            checks++; if (cmd !== memf(k - 16'd1)) $display("FAIL stream_cmd: got %h want %h", cmd, memf(k - 16'd1)); else passed++;
        end
    endtask

    task automatic test_hold();
        int acks;
        reset_dut();
        tick();
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            if (mem_req && mem_ack) acks++;
            tick();
        end
        checks++; if (acks != 4) $display("FAIL hold_acks: got %0d want 4", acks); else passed++;
        checks++; if (mem_req !== 1'b0) $display("FAIL hold_req: got %b want 0", mem_req); else passed++;
        checks++; if (cmd_valid !== 1'b1 || cmd_pc !== 16'h0001)
            $display("FAIL hold_head: got v=%b pc=%h want v=1 pc=0001", cmd_valid, cmd_pc); else passed++;
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0005)
            $display("FAIL hold_resume: got req=%b addr=%h want req=1 addr=0005", mem_req, mem_addr); else passed++;
        checks++; if (cmd_pc !== 16'h0002) $display("FAIL hold_pop: got %h want 0002", cmd_pc); else passed++;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_req && mem_ack) acks++;
            tick();
        end
        checks++; if (acks != 1 || mem_req !== 1'b0)
            $display("FAIL hold_single: got acks=%0d req=%b want acks=1 req=0", acks, mem_req); else passed++;
    endtask

    task automatic test_redirect_drain();
        int n;
        reset_dut();
        cmd_ready = 1'b1;
        tick();
        tick();
        ack_delay = 3;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0003)
            $display("FAIL drain_setup: got req=%b addr=%h want req=1 addr=0003", mem_req, mem_addr); else passed++;
        redirect = 1'b1; redirect_pc = 16'h3000;
        tick();
        redirect = 1'b0;
        n = 0;
        while (!(mem_req && mem_ack) && n < 10) begin
            checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0003 || cmd_valid !== 1'b0)
                $display("FAIL drain_hold: got req=%b addr=%h v=%b want req=1 addr=0003 v=0", mem_req, mem_addr, cmd_valid); else passed++;
            tick();
            n++;
        end
        checks++; if (n >= 10) $display("FAIL drain_timeout: got %0d cycles want <10", n); else passed++;
        ack_delay = 0;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h3000 || cmd_valid !== 1'b0)
            $display("FAIL drain_exit: got req=%b addr=%h v=%b want req=1 addr=3000 v=0", mem_req, mem_addr, cmd_valid); else passed++;
        tick();
        checks++; if (cmd_valid !== 1'b1 || cmd_pc !== 16'h3000 || cmd !== memf(16'h3000))
            $display("FAIL drain_first: got v=%b pc=%h cmd=%h want v=1 pc=3000 cmd=%h", cmd_valid, cmd_pc, cmd, memf(16'h3000)); else passed++;
    endtask

    task automatic test_wrap();
        logic [15:0] got[$];
        logic [15:0] want;
        int n;
        reset_dut();
        cmd_ready = 1'b1;
        tick();
        tick();
        tick();
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        checks++; if (cmd_valid !== 1'b0) $display("FAIL wrap_flush: got %b want 0", cmd_valid); else passed++;
        n = 0;
        while (got.size() < 4 && n < 20) begin
            if (cmd_valid && cmd_ready) got.push_back(cmd_pc);
            tick();
            n++;
        end
        checks++; if (got.size() != 4) $display("FAIL wrap_count: got %0d want 4", got.size()); else passed++;
        want = 16'hFFFE;
        for (int i = 0; i < 4; i++) begin
            checks++; if (i >= got.size() || got[i] !== want)
                $display("FAIL wrap_pc: got %h want %h", (i < got.size()) ? got[i] : 16'hxxxx, want); else passed++;
            want = want + 16'd1;
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        tick();
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        tick();
        ack_delay = 50;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0042 || cmd_valid !== 1'b1)
            $display("FAIL midrst_setup: got req=%b addr=%h v=%b want req=1 addr=0042 v=1", mem_req, mem_addr, cmd_valid); else passed++;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || cmd_valid !== 1'b0)
            $display("FAIL midrst_outputs: got req=%b v=%b want req=0 v=0", mem_req, cmd_valid); else passed++;
        checks++; if (mem_addr !== 16'h0001 || cmd_pc !== 16'h0000)
            $display("FAIL midrst_addr: got addr=%h pc=%h want addr=0001 pc=0000", mem_addr, cmd_pc); else passed++;
        #1;
        rst = 1'b0; mem_ack = 1'b0; wait_n = 0; ack_delay = 0;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001)
            $display("FAIL midrst_restart: got req=%b addr=%h want req=1 addr=0001", mem_req, mem_addr); else passed++;
        tick();
        checks++; if (cmd_valid !== 1'b1 || cmd_pc !== 16'h0001)
            $display("FAIL midrst_first: got v=%b pc=%h want v=1 pc=0001", cmd_valid, cmd_pc); else passed++;
    endtask

    // The core must see an unbroken +1 PC sequence that restarts at every redirect target.
    task automatic test_random();
        logic [15:0] exp_pc;
        logic [15:0] old_addr;
        bit hold_req;
        bit was_redir;
        int pops;
        reset_dut();
        rand_delay = 1'b1;
        ack_delay = $urandom_range(0, 3);
        exp_pc = 16'h0001;
        pops = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            cmd_ready   = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 39) == 0);
            redirect_pc = 16'($urandom);
            if (cmd_valid && cmd_ready) begin
                checks++; if (cmd_pc !== exp_pc) $display("FAIL rand_pc: got %h want %h", cmd_pc, exp_pc); else passed++;
                checks++; if (cmd !== memf(exp_pc)) $display("FAIL rand_cmd: got %h want %h", cmd, memf(exp_pc)); else passed++;
                exp_pc = exp_pc + 16'd1;
                pops++;
            end
            hold_req  = mem_req && !mem_ack;
            old_addr  = mem_addr;
            was_redir = redirect;
            if (redirect) exp_pc = redirect_pc;
            tick();
            if (hold_req) begin
                checks++; if (mem_req !== 1'b1 || mem_addr !== old_addr)
                    $display("FAIL rand_req_stable: got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, old_addr); else passed++;
            end
            if (was_redir) begin
                checks++; if (cmd_valid !== 1'b0) $display("FAIL rand_flush: got %b want 0", cmd_valid); else passed++;
            end
        end
        redirect = 1'b0;
        cmd_ready = 1'b0;
        checks++; if (pops < 200) $display("FAIL rand_progress: got %0d pops want >=200", pops); else passed++;
`ifdef LC3_FETCH_PERF_EN
        checks++; if (fetch_count !== 16'(pops)) $display("FAIL rand_fetch_count: got %0d want %0d", fetch_count, pops); else passed++;
`endif
    endtask

`ifdef LC3_FETCH_PERF_EN
    task automatic test_perf();
        int pops;
        int n;
        reset_dut();
        cmd_ready = 1'b1;
        pops = 0;
        n = 0;
        while (pops < 10 && n < 100) begin
            if (cmd_valid) pops++;
            tick();
            n++;
        end
        cmd_ready = 1'b0;
        checks++; if (fetch_count !== 16'd10) $display("FAIL perf_count: got %0d want 10", fetch_count); else passed++;
        redirect = 1'b1; redirect_pc = 16'h1234;
        tick();
        redirect = 1'b0;
        checks++; if (fetch_count !== 16'd10) $display("FAIL perf_redirect: got %0d want 10", fetch_count); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_redirect_drain();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef LC3_FETCH_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
